// File: rtl/parser_extract_phv.sv
// parser_extract_phv: applies ten parse actions to a header window in a three-stage
// pipeline and queues the resulting PHVs in a first-word-fall-through buffer.
module parser_extract_phv #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4,
  parameter int C_PARSER_RAM_WIDTH = 160,
  parameter int C_PHV_WIDTH        = 896,
  parameter int C_FIFO_DEPTH       = 4
) (
  input  logic                                      axis_clk,
  input  logic                                      aresetn,
  input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   tdata_segs,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_1st,
  input  logic                                      segs_valid,
  input  logic [C_PARSER_RAM_WIDTH-1:0]             parser_bram_out,
  output logic [C_PHV_WIDTH-1:0]                    phv_out,
  output logic                                      phv_valid,
  input  logic                                      phv_ready,
  output logic                                      drop_pulse,
  output logic [15:0]                               drop_cnt
);

  localparam int WIN_W     = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
  localparam int WIN_BYTES = WIN_W / 8;
  localparam int BYTE_AW   = $clog2(WIN_BYTES);
  localparam int NUM_ACT   = 10;
  localparam int CNT_W     = $clog2(C_FIFO_DEPTH + 1);

  logic                          s1_valid;
  logic [WIN_W-1:0]              s1_data;
  logic [C_AXIS_TUSER_WIDTH-1:0] s1_tuser;
  logic [C_PARSER_RAM_WIDTH-1:0] s1_act;
  logic [7:0]                    s1_bytes [WIN_BYTES];

  logic [47:0]                   ext_val  [NUM_ACT];
  logic [1:0]                    ext_type [NUM_ACT];
  logic [2:0]                    ext_idx  [NUM_ACT];
  logic [NUM_ACT-1:0]            ext_app;

  logic                          s2_valid;
  logic [47:0]                   s2_val  [NUM_ACT];
  logic [1:0]                    s2_type [NUM_ACT];
  logic [2:0]                    s2_idx  [NUM_ACT];
  logic [NUM_ACT-1:0]            s2_app;
  logic [C_AXIS_TUSER_WIDTH-1:0] s2_tuser;

  logic [47:0]                   win;
  int                            off;
  int                            nbytes;
  int                            pos;
  logic [BYTE_AW-1:0]            pos_idx;
  logic [3*NUM_ACT-1:0]          rsvd_unused;

  logic [C_PHV_WIDTH-1:0]        phv_asm;
  logic [C_PHV_WIDTH-1:0]        fifo_q [C_FIFO_DEPTH];
  logic [CNT_W-1:0]              count;
  logic                          accept;
  logic                          pop;
  int                            wr_idx;

  // Credit covers buffered PHVs plus both pipeline stages, so a write can never find the buffer full.
  always_comb begin
    accept = segs_valid &&
             ((int'(count) + int'(s1_valid) + int'(s2_valid)) < C_FIFO_DEPTH);
    pop    = phv_valid && phv_ready;
    wr_idx = int'(count) - int'(pop);
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      drop_pulse <= 1'b0;
      drop_cnt   <= 16'd0;
    end else begin
      s1_valid   <= accept;
      s2_valid   <= s1_valid;
      drop_pulse <= segs_valid && !accept;
      if (segs_valid && !accept && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (accept) begin
      s1_data  <= tdata_segs;
      s1_tuser <= tuser_1st;
      s1_act   <= parser_bram_out;
    end
    s2_val   <= ext_val;
    s2_type  <= ext_type;
    s2_idx   <= ext_idx;
    s2_app   <= ext_app;
    s2_tuser <= s1_tuser;
  end

  always_comb begin
    for (int b = 0; b < WIN_BYTES; b++) begin
      s1_bytes[b] = s1_data[8*b +: 8];
    end
  end

  // Always gather six bytes; shorter containers keep the leading (most significant) bytes.
  always_comb begin
    win         = '0;
    off         = 0;
    nbytes      = 0;
    pos         = 0;
    pos_idx     = '0;
    rsvd_unused = '0;
    for (int i = 0; i < NUM_ACT; i++) begin
      off         = int'(s1_act[16*i+9 +: 7]);
      ext_type[i] = s1_act[16*i+7 +: 2];
      ext_idx[i]  = s1_act[16*i+4 +: 3];
      ext_app[i]  = s1_act[16*i] && (s1_act[16*i+7 +: 2] != 2'b11);
      rsvd_unused[3*i +: 3] = s1_act[16*i+1 +: 3];
      nbytes      = 2 * int'(s1_act[16*i+7 +: 2]) + 2;
      win         = '0;
      for (int k = 0; k < 6; k++) begin
        pos     = off + k;
        pos_idx = BYTE_AW'(pos);
        if (pos < WIN_BYTES) begin
          win[8*(5-k) +: 8] = s1_bytes[pos_idx];
        end
      end
      case (s1_act[16*i+7 +: 2])
        2'b00:   ext_val[i] = {32'd0, win[47:32]};
        2'b01:   ext_val[i] = {16'd0, win[47:16]};
        default: ext_val[i] = win;
      endcase
      if (off + nbytes > WIN_BYTES) begin
        ext_val[i] = '0;
      end
    end
  end

  // Later actions overwrite earlier ones, giving the highest index priority.
  always_comb begin
    phv_asm = '0;
    for (int i = 0; i < NUM_ACT; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (s2_app[i] && s2_idx[i] == 3'(j)) begin
          case (s2_type[i])
            2'b00:   phv_asm[16*j +: 16]       = s2_val[i][15:0];
            2'b01:   phv_asm[128 + 32*j +: 32] = s2_val[i][31:0];
            2'b10:   phv_asm[384 + 48*j +: 48] = s2_val[i];
            default: ;
          endcase
        end
      end
    end
    phv_asm[768 +: C_AXIS_TUSER_WIDTH] = s2_tuser;
  end

  // Shift-register buffer: entry 0 is the head and drives phv_out directly.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      count <= '0;
      for (int j = 0; j < C_FIFO_DEPTH; j++) begin
        fifo_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < C_FIFO_DEPTH; j++) begin
        if (s2_valid && j == wr_idx) begin
          fifo_q[j] <= phv_asm;
        end else if (pop && j < C_FIFO_DEPTH - 1) begin
          fifo_q[j] <= fifo_q[(j + 1) % C_FIFO_DEPTH];
        end
      end
      count <= count + CNT_W'(s2_valid) - CNT_W'(pop);
    end
  end

  assign phv_valid = (count != '0);
  assign phv_out   = fifo_q[0];

endmodule

// File: tb/tb_parser_extract_phv.sv
// tb_parser_extract_phv: randomized and directed scenarios checked against a
// transaction-level model of admission, extraction and in-order delivery.
module tb_parser_extract_phv;

  localparam int UW = 128;
  localparam int RW = 160;
  localparam int PW = 896;
  localparam int FD = 4;
  localparam int WB = 1024;

  logic          axis_clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [WB-1:0] tdata_segs = '0;
  logic [UW-1:0] tuser_1st = '0;
  logic          segs_valid = 1'b0;
  logic [RW-1:0] parser_bram_out = '0;
  logic [PW-1:0] phv_out;
  logic          phv_valid;
  logic          phv_ready = 1'b0;
  logic          drop_pulse;
  logic [15:0]   drop_cnt;

  always #5 axis_clk = ~axis_clk;

  parser_extract_phv dut (
    .axis_clk        (axis_clk),
    .aresetn         (aresetn),
    .tdata_segs      (tdata_segs),
    .tuser_1st       (tuser_1st),
    .segs_valid      (segs_valid),
    .parser_bram_out (parser_bram_out),
    .phv_out         (phv_out),
    .phv_valid       (phv_valid),
    .phv_ready       (phv_ready),
    .drop_pulse      (drop_pulse),
    .drop_cnt        (drop_cnt)
  );

  typedef struct {
    int            cyc;
    logic [PW-1:0] phv;
  } entry_t;

  entry_t        exp_q[$];
  int            cyc_num = 0;
  logic          drop_prev = 1'b0;
  logic [15:0]   cnt_m = 16'd0;
  logic          exp_valid;
  logic [PW-1:0] exp_phv;
  logic          exp_drop;
  logic [15:0]   exp_cnt;
  int            n_compared = 0;
  int            n_mismatched = 0;

  function automatic logic [PW-1:0] ref_phv(input logic [WB-1:0] d, input logic [RW-1:0] a,
                                            input logic [UW-1:0] u);
    logic [47:0]   c2 [8];
    logic [47:0]   c4 [8];
    logic [47:0]   c6 [8];
    logic [PW-1:0] r;
    logic [15:0]   act;
    logic [47:0]   val;
    int            off, ty, idx, n;
    for (int j = 0; j < 8; j++) begin
      c2[j] = '0; c4[j] = '0; c6[j] = '0;
    end
    for (int i = 0; i < 10; i++) begin
      act = a[16*i +: 16];
      off = int'(act[15:9]);
      ty  = int'(act[8:7]);
      idx = int'(act[6:4]);
      if (act[0] && ty != 3) begin
        n   = 2 * ty + 2;
        val = '0;
        if (off + n <= 128) begin
          for (int k = 0; k < n; k++) val = (val << 8) | 48'(d[8*(off+k) +: 8]);
        end
        if (ty == 0) c2[idx] = val;
        else if (ty == 1) c4[idx] = val;
        else c6[idx] = val;
      end
    end
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[16*j +: 16]       = c2[j][15:0];
      r[128 + 32*j +: 32] = c4[j][31:0];
      r[384 + 48*j +: 48] = c6[j];
    end
    r[768 +: UW] = u;
    return r;
  endfunction

  function automatic logic [15:0] mk(input int off, input int ty, input int idx);
    logic [6:0] o;
    logic [1:0] t;
    logic [2:0] x;
    o = off[6:0];
    t = ty[1:0];
    x = idx[2:0];
    return {o, t, x, 3'b000, 1'b1};
  endfunction

  function automatic logic [WB-1:0] rand_win();
    logic [WB-1:0] w;
    for (int i = 0; i < WB / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [RW-1:0] rand_acts();
    logic [RW-1:0] a;
    for (int i = 0; i < RW / 16; i++) a[16*i +: 16] = 16'($urandom);
    return a;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [UW-1:0] u;
    for (int i = 0; i < UW / 32; i++) u[32*i +: 32] = $urandom;
    return u;
  endfunction

  // One cycle: publish expectations for the current cycle, drive inputs, then advance the model.
  task automatic advance(input logic sv, input logic [WB-1:0] d, input logic [RW-1:0] a,
                         input logic [UW-1:0] u, input logic rdy);
    logic   adm;
    entry_t e;
    @(negedge axis_clk);
    cyc_num++;
    exp_valid = 1'b0;
    if (exp_q.size() > 0) exp_valid = (exp_q[0].cyc <= cyc_num - 3);
    exp_phv  = exp_valid ? exp_q[0].phv : '0;
    exp_drop = drop_prev;
    exp_cnt  = cnt_m;
    aresetn         = 1'b1;
    segs_valid      = sv;
    tdata_segs      = d;
    parser_bram_out = a;
    tuser_1st       = u;
    phv_ready       = rdy;
    adm       = sv && (exp_q.size() < FD);
    drop_prev = sv && !adm;
    if (drop_prev && cnt_m != 16'hFFFF) cnt_m++;
    if (exp_valid && rdy) void'(exp_q.pop_front());
    if (adm) begin
      e.cyc = cyc_num;
      e.phv = ref_phv(d, a, u);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge axis_clk);
      cyc_num++;
      aresetn    = 1'b0;
      segs_valid = 1'b0;
      phv_ready  = 1'b0;
    end
    exp_q.delete();
    drop_prev = 1'b0;
    cnt_m     = 16'd0;
  endtask

  task automatic test_reset();
    do_reset(2);
    advance(1'b1, rand_win(), rand_acts(), rand_user(), 1'b1);
    n_compared += 4;
    if (phv_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset.valid: got %b want 0", phv_valid); end
    if (phv_out !== '0) begin n_mismatched++; $display("[TB] FAIL reset.phv_out: got %h want 0", phv_out); end
    if (drop_pulse !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset.drop_pulse: got %b want 0", drop_pulse); end
    if (drop_cnt !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset.drop_cnt: got %h want 0", drop_cnt); end
    // The window driven in the first released cycle must still come out.
    for (int k = 1; k < 6; k++) begin
      advance(1'b0, '0, '0, '0, 1'b1);
      n_compared++;
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL reset.first_valid k=%0d: got %b want %b", k, phv_valid, exp_valid); end
      if (exp_valid) begin
        n_compared++;
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL reset.first_phv: got %h want %h", phv_out, exp_phv); end
      end
    end
  endtask

  task automatic test_single_extract();
    logic [WB-1:0] d;
    logic [RW-1:0] a;
    logic [767:0]  want;
    d = rand_win();
    d[8*12 +: 8] = 8'h81;
    d[8*13 +: 8] = 8'h00;
    a = '0;
    a[15:0] = mk(12, 0, 0);
    want = '0;
    want[15:0] = 16'h8100;
    for (int k = 0; k < 6; k++) begin
      advance(k == 0, d, a, rand_user(), 1'b1);
      n_compared += 2;
      if (phv_valid !== (k == 3)) begin n_mismatched++; $display("[TB] FAIL single.latency T+%0d: got %b want %b", k, phv_valid, (k == 3)); end
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL single.model_valid T+%0d: got %b want %b", k, phv_valid, exp_valid); end
      if (k == 3) begin
        n_compared += 2;
        if (phv_out[767:0] !== want) begin n_mismatched++; $display("[TB] FAIL single.containers: got %h want %h", phv_out[767:0], want); end
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL single.phv: got %h want %h", phv_out, exp_phv); end
      end
    end
  endtask

  task automatic test_six_byte();
    logic [WB-1:0] d;
    logic [RW-1:0] a;
    d = rand_win();
    for (int b = 0; b < 6; b++) d[8*b +: 8] = 8'(b + 1);
    a = '0;
    a[16*5 +: 16] = mk(0, 2, 7);
    for (int k = 0; k < 5; k++) begin
      advance(k == 0, d, a, rand_user(), 1'b1);
      n_compared++;
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL six.valid T+%0d: got %b want %b", k, phv_valid, exp_valid); end
      if (k == 3) begin
        n_compared += 2;
        if (phv_out[720 +: 48] !== 48'h010203040506) begin n_mismatched++; $display("[TB] FAIL six.container: got %h want 010203040506", phv_out[720 +: 48]); end
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL six.phv: got %h want %h", phv_out, exp_phv); end
      end
    end
  endtask

  task automatic test_range_conflict();
    logic [WB-1:0] d;
    logic [RW-1:0] a;
    d = rand_win();
    d[8*20 +: 8]  = 8'hAA;
    d[8*21 +: 8]  = 8'hBB;
    d[8*40 +: 8]  = 8'h5C;
    d[8*41 +: 8]  = 8'hD3;
    d[8*126 +: 8] = 8'hEE;
    d[8*127 +: 8] = 8'hFF;
    a = '0;
    a[16*3 +: 16] = mk(126, 1, 2);
    a[16*4 +: 16] = mk(20, 0, 1);
    a[16*9 +: 16] = mk(40, 0, 1);
    for (int k = 0; k < 5; k++) begin
      advance(k == 0, d, a, rand_user(), 1'b1);
      n_compared++;
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL conflict.valid T+%0d: got %b want %b", k, phv_valid, exp_valid); end
      if (k == 3) begin
        n_compared += 3;
        if (phv_out[192 +: 32] !== 32'd0) begin n_mismatched++; $display("[TB] FAIL conflict.out_of_range: got %h want 0", phv_out[192 +: 32]); end
        if (phv_out[16 +: 16] !== 16'h5CD3) begin n_mismatched++; $display("[TB] FAIL conflict.priority: got %h want 5cd3", phv_out[16 +: 16]); end
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL conflict.phv: got %h want %h", phv_out, exp_phv); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      advance(k < 2, rand_win(), rand_acts(), rand_user(), 1'b1);
      n_compared += 2;
      if (phv_valid !== (k == 3 || k == 4)) begin n_mismatched++; $display("[TB] FAIL b2b.timing T+%0d: got %b want %b", k, phv_valid, (k == 3 || k == 4)); end
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL b2b.model_valid T+%0d: got %b want %b", k, phv_valid, exp_valid); end
      if (exp_valid) begin
        n_compared++;
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL b2b.phv: got %h want %h", phv_out, exp_phv); end
      end
    end
    n_compared++;
    if (drop_cnt !== 16'd0) begin n_mismatched++; $display("[TB] FAIL b2b.drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_random();
    logic sv, rdy;
    for (int k = 0; k < 110; k++) begin
      sv  = (k < 100) && ($urandom_range(0, 1) == 1);
      rdy = (k >= 100) || ($urandom_range(0, 2) != 0);
      advance(sv, rand_win(), rand_acts(), rand_user(), rdy);
      n_compared += 3;
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL random.valid cyc %0d: got %b want %b", k, phv_valid, exp_valid); end
      if (drop_pulse !== exp_drop) begin n_mismatched++; $display("[TB] FAIL random.drop_pulse cyc %0d: got %b want %b", k, drop_pulse, exp_drop); end
      if (drop_cnt !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL random.drop_cnt cyc %0d: got %0d want %0d", k, drop_cnt, exp_cnt); end
      if (exp_valid) begin
        n_compared++;
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL random.phv cyc %0d: got %h want %h", k, phv_out, exp_phv); end
      end
    end
  endtask

  task automatic test_overflow();
    int drops_seen;
    int pops_seen;
    int first_pop;
    int last_pop;
    logic rdy;
    drops_seen = 0;
    pops_seen  = 0;
    first_pop  = -1;
    last_pop   = -1;
    do_reset(1);
    for (int k = 0; k < 24; k++) begin
      rdy = (k >= 16);
      advance((k % 3 == 0) && (k <= 12), rand_win(), rand_acts(), rand_user(), rdy);
      if (drop_pulse === 1'b1) drops_seen++;
      if (phv_valid === 1'b1 && rdy) begin
        pops_seen++;
        if (first_pop < 0) first_pop = k;
        last_pop = k;
      end
      n_compared += 3;
      if (phv_valid !== exp_valid) begin n_mismatched++; $display("[TB] FAIL overflow.valid k=%0d: got %b want %b", k, phv_valid, exp_valid); end
      if (drop_pulse !== exp_drop) begin n_mismatched++; $display("[TB] FAIL overflow.drop_pulse k=%0d: got %b want %b", k, drop_pulse, exp_drop); end
      if (drop_cnt !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL overflow.drop_cnt k=%0d: got %0d want %0d", k, drop_cnt, exp_cnt); end
      if (exp_valid) begin
        n_compared++;
        if (phv_out !== exp_phv) begin n_mismatched++; $display("[TB] FAIL overflow.phv k=%0d: got %h want %h", k, phv_out, exp_phv); end
      end
    end
    n_compared += 5;
    if (drops_seen !== 1) begin n_mismatched++; $display("[TB] FAIL overflow.drop_pulses: got %0d want 1", drops_seen); end
    if (drop_cnt !== 16'd1) begin n_mismatched++; $display("[TB] FAIL overflow.drop_total: got %0d want 1", drop_cnt); end
    if (pops_seen !== 4) begin n_mismatched++; $display("[TB] FAIL overflow.pops: got %0d want 4", pops_seen); end
    if (first_pop !== 16) begin n_mismatched++; $display("[TB] FAIL overflow.first_pop: got %0d want 16", first_pop); end
    if (last_pop - first_pop !== 3) begin n_mismatched++; $display("[TB] FAIL overflow.consecutive: got span %0d want 3", last_pop - first_pop); end
  endtask

  task automatic test_reset_midflight();
    int valid_seen;
    valid_seen = 0;
    for (int k = 0; k < 6; k++) begin
      advance(k == 0 || k == 5, rand_win(), rand_acts(), rand_user(), 1'b0);
    end
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      advance(1'b0, '0, '0, '0, 1'b1);
      if (phv_valid === 1'b1) valid_seen++;
      n_compared += 2;
      if (phv_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midflight.valid k=%0d: got %b want 0", k, phv_valid); end
      if (drop_cnt !== 16'd0) begin n_mismatched++; $display("[TB] FAIL midflight.drop_cnt k=%0d: got %0d want 0", k, drop_cnt); end
    end
    n_compared++;
    if (valid_seen !== 0) begin n_mismatched++; $display("[TB] FAIL midflight.leaked: got %0d want 0", valid_seen); end
  endtask

  initial begin
    test_reset();
    test_single_extract();
    test_six_byte();
    test_range_conflict();
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
